// File: rtl/mulf_seq_if.sv
// Command/control bundle between the mulf_seq sequencer, its command source
// and the downstream multifunction register.
interface mulf_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [7:0] cmd_data;
  logic [7:0] q_in;
  logic       ld_n;
  logic       sh_count;
  logic       lr;
  logic       rs;
  logic       up_down;
  logic [7:0] d_out;
  logic       busy;
  logic       done;

  // Command source / register side
  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, q_in,
    input  cmd_ready, ld_n, sh_count, lr, rs, up_down, d_out, busy, done
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, q_in,
    output cmd_ready, ld_n, sh_count, lr, rs, up_down, d_out, busy, done
  );
endinterface

// File: rtl/mulf_seq.sv
// Multifunction-register sequencer: accepts one command, then drives the
// register's load/shift/rotate/count controls once per cycle for cnt+1 cycles
// (LOAD always exactly once), then pulses done for one cycle.
module mulf_seq (
  input  logic       clk,
  input  logic       reset,
  mulf_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_INC  = 3'b101,
    OP_DEC  = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [3:0] rem_q, rem_d;
  logic [7:0] data_q, data_d;

  // State and latched command registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  // Next-state: accept in IDLE, count down in EXEC, single DONE cycle
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = op_e'(bus.cmd_op);
          rem_d   = bus.cmd_cnt;
          data_d  = bus.cmd_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // LOAD leaves after its single cycle regardless of the repeat count
        if (rem_q == 4'd0 || op_q == OP_LOAD) begin
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: hold encoding by default, op encoding only while executing
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.ld_n      = 1'b0;
    bus.d_out     = bus.q_in;
    bus.sh_count  = 1'b0;
    bus.lr        = 1'b0;
    bus.rs        = 1'b0;
    bus.up_down   = 1'b0;
    unique case (state_q)
      S_IDLE: bus.cmd_ready = 1'b1;
      S_EXEC: begin
        bus.busy = 1'b1;
        unique case (op_q)
          OP_LOAD: bus.d_out = data_q;
          OP_SHL: begin
            bus.ld_n     = 1'b1;
            bus.sh_count = 1'b1;
            bus.lr       = 1'b1;
          end
          OP_SHR: begin
            bus.ld_n     = 1'b1;
            bus.sh_count = 1'b1;
          end
          OP_ROL: begin
            bus.ld_n     = 1'b1;
            bus.sh_count = 1'b1;
            bus.rs       = 1'b1;
            bus.lr       = 1'b1;
          end
          OP_ROR: begin
            bus.ld_n     = 1'b1;
            bus.sh_count = 1'b1;
            bus.rs       = 1'b1;
          end
          OP_INC: begin
            bus.ld_n    = 1'b1;
            bus.up_down = 1'b1;
          end
          OP_DEC: bus.ld_n = 1'b1;
          OP_NOP: ;
          default: ;
        endcase
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mulf_seq.sv
// Bench for mulf_seq: drives commands into the sequencer, models the
// downstream multifunction register, and compares controls and Q against
// a per-command arithmetic reference.
module tb_mulf_seq;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] qreg  = 8'h00;
  int         checks = 0;
  int         errors = 0;

  mulf_seq_if bus ();

  mulf_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.q_in = qreg;

  // Downstream multifunction register driven by the sequencer's controls
  always @(posedge clk) begin
    if (!bus.ld_n)              qreg <= bus.d_out;
    else if (bus.sh_count) begin
      case ({bus.rs, bus.lr})
        2'b01:   qreg <= {qreg[6:0], 1'b0};
        2'b00:   qreg <= {1'b0, qreg[7:1]};
        2'b11:   qreg <= {qreg[6:0], qreg[7]};
        default: qreg <= {qreg[0], qreg[7:1]};
      endcase
    end
    else if (bus.up_down)       qreg <= qreg + 8'd1;
    else                        qreg <= qreg - 8'd1;
  end

  typedef struct {
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] data;
    logic [7:0] exp_q;
    int         exp_n;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Effect of one operation on Q
  function automatic logic [7:0] step(input logic [2:0] op, input logic [7:0] data,
                                      input logic [7:0] q);
    case (op)
      3'd0:    return data;
      3'd1:    return {q[6:0], 1'b0};
      3'd2:    return {1'b0, q[7:1]};
      3'd3:    return {q[6:0], q[7]};
      3'd4:    return {q[0], q[7:1]};
      3'd5:    return q + 8'd1;
      3'd6:    return q - 8'd1;
      default: return q;
    endcase
  endfunction

  // Expected {cmd_ready, ld_n, sh_count, lr, rs, up_down, d_out} while executing
  function automatic logic [13:0] exp_ctl(input logic [2:0] op, input logic [7:0] data,
                                          input logic [7:0] q);
    case (op)
      3'd0:    return {1'b0, 5'b00000, data};
      3'd1:    return {1'b0, 5'b11100, q};
      3'd2:    return {1'b0, 5'b11000, q};
      3'd3:    return {1'b0, 5'b11110, q};
      3'd4:    return {1'b0, 5'b11010, q};
      3'd5:    return {1'b0, 5'b10001, q};
      3'd6:    return {1'b0, 5'b10000, q};
      default: return {1'b0, 5'b00000, q};
    endcase
  endfunction

  function automatic logic [13:0] act_ctl();
    return {bus.cmd_ready, bus.ld_n, bus.sh_count, bus.lr, bus.rs, bus.up_down, bus.d_out};
  endfunction

  // Idle/reset output pattern: ready, not busy, no done, hold encoding, d_out=Q
  task automatic chk_hold(input string name);
    chk({name, "_flags"}, {bus.cmd_ready, bus.busy, bus.done, bus.ld_n,
                           bus.sh_count, bus.lr, bus.rs, bus.up_down}, 8'b1000_0000);
    chk({name, "_dout"}, bus.d_out, qreg);
  endtask

  // Issue one command from an IDLE negedge; returns at the IDLE negedge after done.
  // With noise set, cmd_* keep changing with cmd_valid=1 while the command runs.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] data,
                         input int exp_n, input bit noise, output logic [7:0] qfinal);
    logic [7:0] exp_q;
    int n;
    int waited;
    exp_q = qreg;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    bus.cmd_data  = data;
    waited = 0;
    while (!bus.cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", bus.cmd_ready, 1'b1);
    @(negedge clk);
    bus.cmd_valid = noise;
    n = 0;
    while (bus.busy && !bus.done && n < 40) begin
      chk("exec_ctl", act_ctl(), exp_ctl(op, data, exp_q));
      exp_q = step(op, data, exp_q);
      n++;
      if (noise) begin
        bus.cmd_op   = 3'($urandom);
        bus.cmd_cnt  = 4'($urandom);
        bus.cmd_data = 8'($urandom);
      end
      @(negedge clk);
    end
    chk("exec_cycles", n, exp_n);
    chk("done_state", {bus.done, bus.busy, bus.cmd_ready}, 3'b110);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("idle_after", {bus.done, bus.busy, bus.cmd_ready}, 3'b001);
    chk("q_model", qreg, exp_q);
    qfinal = qreg;
  endtask

  initial begin
    vec_t       tbl[$];
    logic [7:0] qf;
    logic [2:0] rop;
    logic [3:0] rcnt;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_cnt   = '0;
    bus.cmd_data  = '0;

    // Reset state
    @(negedge clk);
    chk_hold("reset_state");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_hold("idle_state");

    tbl.push_back('{3'd0, 4'd0,  8'hA5, 8'hA5, 1});
    tbl.push_back('{3'd0, 4'd0,  8'h81, 8'h81, 1});
    tbl.push_back('{3'd3, 4'd2,  8'h5A, 8'h0C, 3});
    tbl.push_back('{3'd0, 4'd0,  8'hFE, 8'hFE, 1});
    tbl.push_back('{3'd5, 4'd3,  8'h11, 8'h02, 4});
    tbl.push_back('{3'd6, 4'd0,  8'h22, 8'h01, 1});
    tbl.push_back('{3'd7, 4'd4,  8'h33, 8'h01, 5});
    tbl.push_back('{3'd2, 4'd1,  8'h44, 8'h00, 2});
    tbl.push_back('{3'd0, 4'd7,  8'h3C, 8'h3C, 1});
    tbl.push_back('{3'd4, 4'd3,  8'h55, 8'hC3, 4});
    tbl.push_back('{3'd1, 4'd0,  8'h66, 8'h86, 1});
    tbl.push_back('{3'd6, 4'd15, 8'h77, 8'h76, 16});
    tbl.push_back('{3'd2, 4'd15, 8'h88, 8'h00, 16});
    tbl.push_back('{3'd6, 4'd0,  8'h99, 8'hFF, 1});

    for (int i = 0; i < tbl.size(); i++) begin
      run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].exp_n, bit'(i % 2), qf);
      chk($sformatf("table_q%0d", i), qf, tbl[i].exp_q);
    end

    // Back-to-back commands with cmd_valid held high: one accept every 3 cycles
    run_cmd(3'd0, 4'd0, 8'h80, 1, 1'b0, qf);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd2;
    bus.cmd_cnt   = 4'd0;
    bus.cmd_data  = 8'h00;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b_ready%0d", i), bus.cmd_ready, (i % 3) == 0);
      chk($sformatf("b2b_done%0d", i), bus.done, (i % 3) == 2);
      chk($sformatf("b2b_q%0d", i), qreg, 8'h80 >> ((i + 1) / 3));
      if (i == 8) bus.cmd_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end_ready", bus.cmd_ready, 1'b1);
    chk("b2b_end_q", qreg, 8'h10);

    // Reset in the middle of a long shift aborts it with no done pulse
    run_cmd(3'd0, 4'd0, 8'hFF, 1, 1'b0, qf);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd1;
    bus.cmd_cnt   = 4'd15;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk_hold("abort_async");
    chk("abort_q", qreg, 8'hE0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone%0d", i), {bus.done, bus.busy}, 2'b00);
      chk($sformatf("abort_qhold%0d", i), qreg, 8'hE0);
    end
    reset = 1'b1;
    @(negedge clk);
    run_cmd(3'd7, 4'd1, 8'h00, 2, 1'b0, qf);
    chk("after_reset_nop_q", qf, 8'hE0);

    // Randomized commands against the reference
    for (int i = 0; i < 60; i++) begin
      rop  = 3'($urandom_range(0, 7));
      rcnt = 4'($urandom_range(0, 15));
      run_cmd(rop, rcnt, 8'($urandom), (rop == 3'd0) ? 1 : int'(rcnt) + 1,
              bit'($urandom_range(0, 1)), qf);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mulf_seq.md
MULF_SEQ -- requirements
Module: mulf_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports, clock and reset first:
  clk  input  1  sole clock, all state updates on rising edge
  reset  input  1  asynchronous active-low reset; 0 forces reset state immediately
  cmd_valid  input  1  command offered
  cmd_ready  output  1  command accepted when cmd_valid=1 and cmd_ready=1 at rising clk
  cmd_op  input  3  opcode: 000 LOAD, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 INC, 110 DEC, 111 NOP
  cmd_cnt  input  4  repeat field; operation executes cmd_cnt+1 times (1..16)
  cmd_data  input  8  load value for LOAD
  q_in  input  8  current Q of the downstream multifunction register
  ld_n  output  1  to register reset/load pin; 0 = load d_out, 1 = operate
  sh_count  output  1  1 = shift/rotate path, 0 = counter path
  lr  output  1  1 = left, 0 = right
  rs  output  1  1 = rotate, 0 = logical shift
  up_down  output  1  1 = increment, 0 = decrement
  d_out  output  8  load data to register
  busy  output  1  command in progress (EXEC or DONE)
  done  output  1  one-cycle pulse at command completion

Function
REQ-002 SHALL implement FSM with states IDLE, EXEC, DONE.
REQ-003 IDLE: cmd_ready=1, busy=0; on handshake SHALL latch cmd_op, cmd_cnt, cmd_data and go to EXEC next cycle.
REQ-004 IDLE and DONE SHALL drive hold: ld_n=0, d_out=q_in, sh_count=0, lr=0, rs=0, up_down=0.
REQ-005 EXEC: cmd_ready=0, busy=1; SHALL issue the latched op once per cycle for latched cnt+1 cycles using a 4-bit remaining counter loaded with cmd_cnt at accept, decrementing each EXEC cycle; leave EXEC for DONE in the cycle remaining=0.
REQ-006 LOAD SHALL ignore cnt and occupy exactly one EXEC cycle with ld_n=0, d_out=latched data.
REQ-007 EXEC encodings (ld_n=1 unless noted): SHL sh_count=1 rs=0 lr=1; SHR sh_count=1 rs=0 lr=0; ROL sh_count=1 rs=1 lr=1; ROR sh_count=1 rs=1 lr=0; INC sh_count=0 up_down=1; DEC sh_count=0 up_down=0; NOP = hold encoding of REQ-004 for cnt+1 cycles. Unused control bits SHALL be 0.
REQ-008 In EXEC, d_out SHALL equal q_in for all ops except LOAD.
REQ-009 DONE SHALL last exactly one cycle with done=1, busy=1, cmd_ready=0, then return to IDLE; cmd_valid in DONE SHALL NOT be accepted.
REQ-010 Minimum command-to-command spacing SHALL be 3 cycles (accept, 1 EXEC, DONE); cnt=15 shift occupies 16 EXEC cycles.
REQ-011 Control outputs SHALL be combinational from state and latched command only (no dependency on cmd_* inputs); d_out additionally from q_in.
REQ-012 Counter wrap in the register (INC of 0xFF, DEC of 0x00) SHALL be no concern of this block; it keeps issuing ops.
REQ-013 cmd_* inputs SHALL be ignored while cmd_ready=0.

Reset
REQ-014 reset=0 SHALL asynchronously force IDLE, remaining=0, latched command=0; outputs cmd_ready=1, busy=0, done=0, hold encoding (ld_n=0, d_out=q_in).
REQ-015 Reset asserted mid-EXEC SHALL abort the command with no done pulse; first handshake after reset release SHALL be accepted normally.

Verification
REQ-016 LOAD 0xA5 with register model Q=0x00 -> one EXEC cycle ld_n=0 d_out=0xA5, done next cycle, Q holds 0xA5 thereafter.
REQ-017 LOAD 0x81 then ROL cnt=2 -> 3 EXEC cycles, Q = 0x03, 0x06, 0x0C; done once; busy high 4 cycles.
REQ-018 LOAD 0xFE then INC cnt=3 -> Q = 0xFF, 0x00, 0x01, 0x02; DEC cnt=0 next -> Q = 0x01.
REQ-019 cmd_valid held high continuously with SHR cnt=0 commands, Q=0x80 -> accept every 3rd cycle, Q = 0x40, 0x20, 0x10, each followed by done.
REQ-020 SHL cnt=15 on Q=0xFF, reset=0 after 5 EXEC cycles -> outputs at reset values immediately, Q holds 0xE0, no done; new NOP cnt=1 after release -> accepted, Q unchanged, done after 2 EXEC cycles.
